rsa_out_capture: RTL and testbench

Receive-side capture block for the RSA pipeline CPU's byte output port. It samples each byte the CPU presents on its data-out/strobe pair during the communication phase and buffers it in a small FIFO. It then drains the bytes to a host-side consumer over a valid/ready stream, marking the final byte once the CPU signals end of program. It sits between the CPU top and the host/UART-side logic, next to the CPU in the system top.

---
 rtl/rsa_io_pkg.sv | 13 +
 rtl/rsa_byte_fifo.sv | 79 +++++++
 rtl/rsa_out_capture.sv | 139 +++++++++++++
 tb/tb_rsa_out_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_io_pkg.sv
// rtl/rsa_io_pkg.sv - shared types for the RSA CPU byte I/O blocks
package rsa_io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } capture_state_t;

    typedef logic [7:0] rsa_byte_t;

endpackage

// File: rtl/rsa_byte_fifo.sv
// rtl/rsa_byte_fifo.sv - byte FIFO with registered output stage and full/empty/count
module rsa_byte_fifo
    import rsa_io_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            wr_en,
    input  rsa_byte_t       wr_data,
    input  logic            rd_ready,
    output rsa_byte_t       rd_data,
    output logic            rd_valid,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    rsa_byte_t       mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   mem_cnt;
    logic            pop;
    logic            load;

    // Writes always land in the array; the output register is refilled from it,
    // so an empty FIFO never passes a byte straight through in the write cycle.
    assign pop   = rd_valid && rd_ready;
    assign load  = (mem_cnt != '0) && (!rd_valid || pop);
    assign count = mem_cnt + {{(CW-1){1'b0}}, rd_valid};
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage array write port; the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (load) begin
                rptr    <= rptr + AW'(1);
                rd_data <= mem[rptr];
            end
            case ({wr_en, load})
                2'b10:   mem_cnt <= mem_cnt + CW'(1);
                2'b01:   mem_cnt <= mem_cnt - CW'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            if (load) begin
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rsa_out_capture.sv
// rtl/rsa_out_capture.sv - captures CPU output bytes and streams them to the host; optional RSA_CAPTURE_CHECKSUM_EN
module rsa_out_capture
    import rsa_io_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  rsa_byte_t         cpu_byte,
    input  logic              cpu_strobe,
    input  logic              cpu_com,
    input  logic              cpu_end,
    output rsa_byte_t         m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [CNT_W-1:0]  byte_count,
    output logic              overflow,
    output logic              busy,
    output logic              done
`ifdef RSA_CAPTURE_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    capture_state_t  state;
    capture_state_t  state_d;
    logic            strobe_q;
    logic            end_q;
    logic            arm;
    logic            qual;
    logic            pop;
    logic            accept;
    logic            end_rise;
    logic            last_pop;
    logic            drain_needed;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign arm      = start && ((state == IDLE) || (state == DONE));
    assign qual     = cpu_strobe && !strobe_q && cpu_com && (state == CAPTURE);
    assign pop      = m_valid && m_ready;
    assign accept   = qual && (!fifo_full || pop);
    assign end_rise = cpu_end && !end_q;
    assign last_pop = pop && (fifo_count == CW'(1));
    // Something remains buffered once this cycle's push and pop have settled.
    assign drain_needed = accept || (!fifo_empty && !last_pop);

    assign m_last = m_valid && (state == DRAIN) && (fifo_count == CW'(1));
    assign busy   = (state == CAPTURE) || (state == DRAIN);

    rsa_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (arm),
        .wr_en    (accept),
        .wr_data  (cpu_byte),
        .rd_ready (m_ready),
        .rd_data  (m_data),
        .rd_valid (m_valid),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Next-state logic for the capture run.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (arm) state_d = CAPTURE;
            CAPTURE: if (end_rise) state_d = drain_needed ? DRAIN : DONE;
            DRAIN:   if (last_pop) state_d = DONE;
            DONE:    if (arm) state_d = CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    // State register and the one-cycle done pulse on entering DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            done  <= (state_d == DONE) && (state != DONE);
        end
    end

    // Edge-detect registers; arming forgets any strobe seen before the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            strobe_q <= arm ? 1'b0 : cpu_strobe;
            end_q    <= cpu_end;
        end
    end

    // Saturating byte counter and sticky drop flag, both cleared per run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_count <= '0;
            overflow   <= 1'b0;
        end else if (arm) begin
            byte_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept && !(&byte_count)) begin
                byte_count <= byte_count + CNT_W'(1);
            end
            if (qual && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef RSA_CAPTURE_CHECKSUM_EN
    // Running XOR of every byte accepted into the FIFO this run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (arm) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum ^ cpu_byte;
        end
    end
`endif

endmodule

// File: tb/tb_rsa_out_capture.sv
// tb/tb_rsa_out_capture.sv - directed self-checking bench for rsa_out_capture
module tb_rsa_out_capture;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       cpu_byte;
    logic             cpu_strobe;
    logic             cpu_com;
    logic             cpu_end;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [CNT_W-1:0] byte_count;
    logic             overflow;
    logic             busy;
    logic             done;
`ifdef RSA_CAPTURE_CHECKSUM_EN
    logic [7:0]       checksum;
`endif

    int checks;
    int errors;
    int done_cnt;
    bit mv_seen;
    logic [7:0] rx_data [$];
    logic       rx_last [$];

    rsa_out_capture #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cpu_byte   (cpu_byte),
        .cpu_strobe (cpu_strobe),
        .cpu_com    (cpu_com),
        .cpu_end    (cpu_end),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .byte_count (byte_count),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
`ifdef RSA_CAPTURE_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every stream transfer and done pulse mid-cycle.
    always @(negedge clk) begin
        if (reset && m_valid && m_ready) begin
            rx_data.push_back(m_data);
            rx_last.push_back(m_last);
        end
        if (done) done_cnt++;
        if (m_valid) mv_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cpu_byte   = b;
        cpu_strobe = 1'b1;
        tick();
        cpu_strobe = 1'b0;
        tick();
    endtask

    task automatic arm_run();
        rx_data.delete();
        rx_last.delete();
        done_cnt = 0;
        mv_seen  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 200), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] exp1 [3];
        exp1[0] = 8'h12; exp1[1] = 8'h34; exp1[2] = 8'h56;
        checks = 0; errors = 0; done_cnt = 0; mv_seen = 1'b0;
        reset = 1'b0; start = 1'b0; cpu_byte = '0; cpu_strobe = 1'b0;
        cpu_com = 1'b0; cpu_end = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_data", m_data, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        tick();

        // three bytes, held until end, then drained
        arm_run();
        check("t1_busy", busy, 1);
        cpu_com = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(exp1[i]);
        cpu_end = 1'b1;
        tick();
        m_ready = 1'b1;
        wait_idle("t1");
        check("t1_rx_size", rx_data.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_data%0d", i), rx_data[i], exp1[i]);
            check($sformatf("t1_last%0d", i), rx_last[i], (i == 2) ? 1 : 0);
        end
        check("t1_byte_count", byte_count, 3);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_overflow", overflow, 0);
`ifdef RSA_CAPTURE_CHECKSUM_EN
        check("t1_checksum", checksum, 8'h70);
`endif

        // overflow: DEPTH+2 bytes with consumer stalled
        cpu_end = 1'b0;
        m_ready = 1'b0;
        arm_run();
        for (int i = 0; i < DEPTH + 2; i++) send_byte(8'h40 + 8'(i));
        check("t2_overflow", overflow, 1);
        check("t2_byte_count", byte_count, DEPTH);
        check("t2_m_valid", m_valid, 1);
        cpu_end = 1'b1;
        tick();
        m_ready = 1'b1;
        wait_idle("t2");
        check("t2_rx_size", rx_data.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t2_data%0d", i), rx_data[i], 8'h40 + 8'(i));
            check($sformatf("t2_last%0d", i), rx_last[i], (i == DEPTH - 1) ? 1 : 0);
        end
        check("t2_done_pulses", done_cnt, 1);

        // strobes outside the communication phase, then an empty end
        cpu_end = 1'b0;
        arm_run();
        cpu_com = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        check("t3_byte_count", byte_count, 0);
        check("t3_m_valid", m_valid, 0);
        check("t3_busy", busy, 1);
        cpu_end = 1'b1;
        tick();
        wait_idle("t3");
        check("t3_done_pulses", done_cnt, 1);
        check("t3_mv_seen", 32'(mv_seen), 0);
        check("t3_overflow", overflow, 0);

        // cpu_end already high at arm is not an end edge
        cpu_com = 1'b1;
        arm_run();
        tick(); tick(); tick();
        check("t5_busy_held", busy, 1);
        cpu_end = 1'b0;
        tick();
        cpu_end = 1'b1;
        tick();
        wait_idle("t5");
        check("t5_done_pulses", done_cnt, 1);

        // latency and a byte arriving with the end edge
        cpu_end = 1'b0;
        m_ready = 1'b0;
        arm_run();
        cpu_byte = 8'h77;
        cpu_strobe = 1'b1;
        tick();
        check("t4_latency_n", m_valid, 0);
        cpu_strobe = 1'b0;
        tick();
        check("t4_latency_n1", m_valid, 1);
        check("t4_first_data", m_data, 8'h77);
        cpu_byte = 8'hA5;
        cpu_strobe = 1'b1;
        cpu_end = 1'b1;
        tick();
        cpu_strobe = 1'b0;
        check("t4_busy", busy, 1);
        m_ready = 1'b1;
        wait_idle("t4");
        check("t4_rx_size", rx_data.size(), 2);
        check("t4_data0", rx_data[0], 8'h77);
        check("t4_last0", rx_last[0], 0);
        check("t4_data1", rx_data[1], 8'hA5);
        check("t4_last1", rx_last[1], 1);
        check("t4_byte_count", byte_count, 2);

        // asynchronous reset mid-drain
        cpu_end = 1'b0;
        m_ready = 1'b0;
        arm_run();
        send_byte(8'h0F);
        send_byte(8'hF0);
        cpu_end = 1'b1;
        tick();
        tick();
        check("t6_busy", busy, 1);
        check("t6_m_valid", m_valid, 1);
        check("t6_m_data", m_data, 8'h0F);
`ifdef RSA_CAPTURE_CHECKSUM_EN
        check("t6_checksum", checksum, 8'hFF);
`endif
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_m_data", m_data, 0);
        check("t6_rst_m_valid", m_valid, 0);
        check("t6_rst_m_last", m_last, 0);
        check("t6_rst_byte_count", byte_count, 0);
        check("t6_rst_overflow", overflow, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
`ifdef RSA_CAPTURE_CHECKSUM_EN
        check("t6_rst_checksum", checksum, 0);
`endif
        #3;
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
